// File: rtl/bls_sub_seq.sv
// -----------------------------------------------------------------------------
// bls_sub_seq
//
// Sequential subtractor: d = a - b - bin, modulo 2^WIDTH. Each clock works on
// one SLICE-bit group. Inside a group the borrows come from a fully expanded
// borrow-lookahead network, so no borrow ripples from bit to bit. A single
// borrow register carries the group borrow-out into the next group. This is
// the subtract-direction counterpart of the 4-bit CLA adder path, meant for
// compare/subtract work where area matters more than latency.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high; overrides everything
//   start  in   request a new operation (accepted in IDLE or DONE)
//   a      in   [WIDTH] minuend, captured on accepted start
//   b      in   [WIDTH] subtrahend, captured on accepted start
//   bin    in   borrow in, captured on accepted start
//   busy   out  high while in RUN
//   done   out  one-cycle pulse; results valid from this cycle on
//   d      out  [WIDTH] difference
//   bout   out  borrow out of MSB (unsigned a < b + bin)
//   zero   out  d == 0
//   ovf    out  signed overflow of the subtraction
// -----------------------------------------------------------------------------
module bls_sub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  // Operand registers shift right one slice per RUN cycle, so the slice being
  // processed is always the low SLICE bits. The operand sign bits are kept
  // separately because they have shifted out by the time ovf is computed.
  logic [WIDTH-1:0] a_r, b_r;
  logic             a_msb, b_msb;
  logic             br_r;
  logic [IDX_W-1:0] idx;

  // Difference accumulator: each slice result enters at the top and the
  // register shifts right, so after NSLICE cycles it holds the full result.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;

  logic [SLICE-1:0] sa, sb, g, p, sd;
  logic [SLICE:0]   br;

  logic accept;
  logic last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (idx == IDX_W'(NSLICE - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // ---------------------------------------------------------------------------
  // Slice datapath: borrow generate/propagate with a flat lookahead network.
  // g: this bit borrows regardless of the incoming borrow (a=0, b=1).
  // p: an incoming borrow passes through this bit (a=0 or b=1).
  // ---------------------------------------------------------------------------
  always_comb begin
    sa    = a_r[SLICE-1:0];
    sb    = b_r[SLICE-1:0];
    g     = ~sa & sb;
    p     = ~sa | sb;
    br[0] = br_r;
    br[1] = g[0] | (p[0] & br[0]);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br[0]);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & br[0]);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & br[0]);
    sd      = sa ^ sb ^ br[SLICE-1:0];
    acc_nxt = {sd, acc[WIDTH-1:SLICE]};
  end

  // ---------------------------------------------------------------------------
  // FSM state register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values, independent of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt
    // unassigned and a latch is never inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = DONE;
      DONE: state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand, borrow, accumulator and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: these are plain flops, not memory arrays, so clearing them all in
      // reset is cheap and gives a defined state after an abort.
      a_r   <= '0;
      b_r   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      br_r  <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      d     <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      br_r  <= bin;
      idx   <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      a_r  <= a_r >> SLICE;
      b_r  <= b_r >> SLICE;
      br_r <= br[SLICE];
      acc  <= acc_nxt;
      idx  <= idx + IDX_W'(1);
      // Results are published only on the final slice, so partial values
      // never appear on d.
      if (last) begin
        d    <= acc_nxt;
        bout <= br[SLICE];
        zero <= (acc_nxt == '0);
        ovf  <= (a_msb != b_msb) && (acc_nxt[WIDTH-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_bls_sub_seq.sv
// -----------------------------------------------------------------------------
// tb_bls_sub_seq
//
// Self-checking bench for bls_sub_seq. The reference model is plain
// 33-bit arithmetic on the operands; flags derive from the result.
// Inputs are driven at the falling edge, outputs sampled at the falling edge.
// -----------------------------------------------------------------------------
module tb_bls_sub_seq;

  localparam int WIDTH  = 32;
  localparam int NSLICE = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             bin;
  logic             busy, done;
  logic [WIDTH-1:0] d;
  logic             bout, zero, ovf;

  int total = 0;
  int bad   = 0;

  bls_sub_seq #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout),
    .zero (zero),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Result vector layout: {bout, zero, ovf, d}
  function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] ma,
                                             input logic [WIDTH-1:0] mb,
                                             input logic             mbin);
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] md;
    diff = {1'b0, ma} - {1'b0, mb} - (WIDTH+1)'(mbin);
    md   = diff[WIDTH-1:0];
    return {diff[WIDTH], (md == '0),
            (ma[WIDTH-1] != mb[WIDTH-1]) && (md[WIDTH-1] != ma[WIDTH-1]), md};
  endfunction

  function automatic logic [WIDTH+2:0] observed();
    return {bout, zero, ovf, d};
  endfunction

  // Launches one operation from IDLE/DONE and waits for done. Operand inputs
  // are scrambled during RUN. lat = rising edges from accept edge to done.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tbin, output int lat, output int bcnt,
                        output logic both);
    lat  = -1;
    bcnt = 0;
    both = 1'b0;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy && done) both = 1'b1;
      if (done) begin
        lat = k - 1;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, bout, zero, ovf, d} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b bout=%b zero=%b ovf=%b d=%h want all 0",
               busy, done, bout, zero, ovf, d);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va [7] = '{32'h0000_0005, 32'h0000_0000, 32'h8000_0000,
                                 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0000,
                                 32'hFFFF_FFFF};
    logic [WIDTH-1:0] vb [7] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001,
                                 32'h1234_5677, 32'hDEAD_BEEF, 32'h0000_0000,
                                 32'h0000_0000};
    logic             vc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    // Hand-derived {bout, zero, ovf, d}
    logic [WIDTH+2:0] ve [7] = '{{3'b000, 32'h0000_0002},
                                 {3'b100, 32'hFFFF_FFFF},
                                 {3'b001, 32'h7FFF_FFFF},
                                 {3'b010, 32'h0000_0000},
                                 {3'b100, 32'hFFFF_FFFF},
                                 {3'b100, 32'hFFFF_FFFF},
                                 {3'b000, 32'hFFFF_FFFE}};
    int   lat, bcnt;
    logic both;
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], vc[i], lat, bcnt, both);
      total++;
      if (lat != NSLICE) begin
        bad++;
        $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, NSLICE);
      end
      total++;
      if (bcnt != NSLICE || both) begin
        bad++;
        $display("FAIL directed%0d_busy: busy cycles %0d want %0d, busy&done=%b",
                 i, bcnt, NSLICE, both);
      end
      total++;
      if (observed() !== ve[i]) begin
        bad++;
        $display("FAIL directed%0d_result: got {bout,zero,ovf,d}=%h want %h",
                 i, observed(), ve[i]);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || observed() !== ve[i]) begin
        bad++;
        $display("FAIL directed%0d_after: got done=%b busy=%b res=%h want 0 0 %h",
                 i, done, busy, observed(), ve[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [WIDTH+2:0] prev, expv;
    logic [WIDTH-1:0] a1, b1;
    int   lat, bcnt, k_done;
    logic both;
    // Known prior result so held outputs can be checked mid-run.
    run_op(32'h0000_0010, 32'h0000_0001, 1'b0, lat, bcnt, both);
    prev = model(32'h0000_0010, 32'h0000_0001, 1'b0);
    a1   = $urandom;
    b1   = $urandom;
    expv = model(a1, b1, 1'b0);
    @(negedge clk);
    a = a1; b = b1; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k_done = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        k_done = k;
        break;
      end
      if (k == 3) begin
        start = 1'b1;
        a = ~a1; b = a1; bin = 1'b1;
      end else if (k == 4) begin
        start = 1'b0;
      end
      if (k == 5) begin
        total++;
        if (observed() !== prev) begin
          bad++;
          $display("FAIL hold_during_run: got %h want %h", observed(), prev);
        end
      end
    end
    total++;
    if (k_done != NSLICE + 1) begin
      bad++;
      $display("FAIL ignore_start_latency: got %0d want %0d", k_done - 1, NSLICE);
    end
    total++;
    if (observed() !== expv) begin
      bad++;
      $display("FAIL ignore_start_result: got %h want %h", observed(), expv);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start_no_relaunch: busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH+2:0] q[$];
    logic [WIDTH+2:0] expv;
    logic [WIDTH-1:0] ta, tb;
    logic             tbi;
    int               k_done;
    ta = $urandom; tb = $urandom; tbi = 1'($urandom);
    @(negedge clk);
    a = ta; b = tb; bin = tbi; start = 1'b1;
    q.push_back(model(ta, tb, tbi));
    @(posedge clk);
    for (int n = 0; n < 6; n++) begin
      k_done = -1;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (done) begin
          k_done = c;
          break;
        end
        a = $urandom; b = $urandom; bin = 1'($urandom);
      end
      total++;
      if (k_done != NSLICE + 1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL b2b%0d_period: got %0d cycles busy=%b want %0d busy=0",
                 n, k_done, busy, NSLICE + 1);
      end
      if (k_done < 0) break;
      expv = q.pop_front();
      total++;
      if (observed() !== expv) begin
        bad++;
        $display("FAIL b2b%0d_result: got %h want %h", n, observed(), expv);
      end
      if (n < 5) begin
        ta = $urandom; tb = (n == 2) ? ta : 32'($urandom); tbi = 1'($urandom);
        a = ta; b = tb; bin = tbi;
        q.push_back(model(ta, tb, tbi));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int   lat, bcnt;
    logic both, seen;
    logic [WIDTH+2:0] expv;
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, lat, bcnt, both);
    @(negedge clk);
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, bout, zero, ovf, d} !== '0) begin
      bad++;
      $display("FAIL reset_mid_state: got busy=%b done=%b bout=%b zero=%b ovf=%b d=%h want all 0",
               busy, done, bout, zero, ovf, d);
    end
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_mid_abort: got done/busy activity after reset want none");
    end
    run_op(32'hCAFE_0000, 32'h0000_BABE, 1'b1, lat, bcnt, both);
    expv = model(32'hCAFE_0000, 32'h0000_BABE, 1'b1);
    total++;
    if (lat != NSLICE || observed() !== expv) begin
      bad++;
      $display("FAIL reset_mid_restart: got lat=%0d res=%h want lat=%0d res=%h",
               lat, observed(), NSLICE, expv);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ta, tb;
    logic             tbi;
    logic [WIDTH+2:0] expv;
    int   lat, bcnt;
    logic both;
    for (int i = 0; i < 30; i++) begin
      ta  = $urandom;
      tbi = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       tb = ta;
        1:       tb = ta + 32'd1;
        2:       tb = ta - 32'd1;
        default: tb = $urandom;
      endcase
      expv = model(ta, tb, tbi);
      run_op(ta, tb, tbi, lat, bcnt, both);
      total++;
      if (lat != NSLICE || both || observed() !== expv) begin
        bad++;
        $display("FAIL random%0d: a=%h b=%h bin=%b got lat=%0d res=%h want lat=%0d res=%h",
                 i, ta, tb, tbi, lat, observed(), NSLICE, expv);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bls_sub_seq.md
Name: bls_sub_seq

Overview:
- Sequential multi-cycle subtractor that computes d = a − b − bin.
- Processes one 4-bit slice per clock, using borrow-lookahead logic inside each slice.
- Borrow-domain counterpart of the 4-bit carry-lookahead adder path: shares its generate/propagate structure, but runs the subtract direction.
- Sits beside the CLA adder in the ALU datapath; serves compare/subtract operations where area matters more than latency.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; fixed lookahead group size.
- NSLICE, WIDTH/SLICE (derived, 8 at default), number of processing cycles.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled on the rising edge.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow in; captured on an accepted start.
- busy  output  1  high while an operation is in progress (state RUN).
- done  output  1  one-cycle pulse; results valid from this cycle on.
- d  output  WIDTH  difference a − b − bin, modulo 2^WIDTH.
- bout  output  1  borrow out of the MSB; 1 iff unsigned a < b + bin.
- zero  output  1  1 iff d == 0.
- ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]).

Behaviour:
- Reset is synchronous, active-high, and has priority over everything.
  - state = IDLE; busy = done = bout = zero = ovf = 0; d = 0.
  - Slice index, operand registers and the borrow register are cleared.
  - Reset during RUN aborts the operation: no done pulse; outputs go to 0.
- States: IDLE, RUN, DONE.
  - IDLE: start = 1 → capture a, b, bin; idx = 0; go to RUN.
  - RUN: each edge processes slice idx; increments idx; updates the borrow register.
    - After slice NSLICE−1: go to DONE and load d/bout/zero/ovf from the internal accumulator.
  - DONE: done = 1 for exactly this cycle.
    - start = 1 → accept a new operation (as in IDLE) and go to RUN.
    - Otherwise go to IDLE.
- Start handling:
  - start is ignored while in RUN; operands do not change mid-operation.
  - start has no effect on outputs until the next completion.
- Latency: start sampled at edge T0 → done high in the cycle following edge T0+NSLICE (8 cycles at default).
  - Throughput with start held high: one result every NSLICE+1 cycles (9 at default).
- Slice logic, bit i within the slice, borrow chain br0 = borrow register:
  - gi = ~ai & bi
  - pi = ~ai | bi
  - br(i+1) = gi | pi·br(i), fully expanded lookahead form; no ripple between bits inside a slice.
  - di = ai ^ bi ^ br(i).
  - br4 is stored as the borrow for the next slice.
- Output registers update only on entry to DONE.
  - d, bout, zero and ovf hold their values through IDLE and RUN until the next completion.
  - Intermediate slice results are never visible on d.
- bout is the borrow out of the final slice. zero is computed from the full WIDTH result. ovf uses the captured a, b and the final d.
- Boundary cases:
  - a == b with bin = 1 → d all ones, bout = 1.
  - bin = 1 with a = b = 0 → same as above.
- busy = 1 exactly in RUN; busy and done are never both high.

Test Plan:
- Basic subtract: a=0x00000005, b=0x00000003, bin=0, start pulse → after 8 cycles done=1 for one cycle; d=0x00000002, bout=0, zero=0, ovf=0; busy high for the 8 RUN cycles.
- Unsigned underflow: a=0x00000000, b=0x00000001, bin=0 → d=0xFFFFFFFF, bout=1, zero=0, ovf=0.
- Signed overflow: a=0x80000000, b=0x00000001, bin=0 → d=0x7FFFFFFF, ovf=1, bout=0.
- Borrow-in to zero: a=0x12345678, b=0x12345677, bin=1 → d=0x00000000, zero=1, bout=0.
  - Also checks the borrow chain across all 8 slices.
- Handshake:
  - Second start with different operands at cycle 3 of RUN → ignored; the result matches the first operands.
  - start held high continuously → done pulses every 9 cycles with correct back-to-back results.
- Reset mid-operation: reset=1 at RUN cycle 4 → next cycle busy=0, done never pulses, d=0, bout=zero=ovf=0, state IDLE.
  - A new start then completes normally.
